// File: rtl/player_cmd_arbiter.sv
// Per-player command FIFOs with round-robin arbitration onto one valid/ready command port.
// Optional periodic gravity scheduler is enabled by defining GRAVITY_EN.

module player_cmd_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic       flush_i,
  input  logic [3:0] data_i,
  output logic [3:0] data_o,
  output logic       empty_o,
  output logic       full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][3:0] mem_q;
  logic [AW-1:0]         wr_q, rd_q;
  logic [AW:0]           cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop_i) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end

  assign data_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
endmodule

module player_cmd_arbiter #(
  parameter int DEPTH          = 4,
  parameter int GRAVITY_PERIOD = 50000000
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic [3:0] control0_i,
  input  logic [3:0] control1_i,
  input  logic [3:0] control2_i,
  input  logic [3:0] control3_i,
  input  logic [3:0] player_active_i,
  input  logic       cmd_ready_i,
  output logic       cmd_valid_o,
  output logic [1:0] cmd_player_o,
  output logic [3:0] cmd_code_o,
  output logic       cmd_gravity_o,
  output logic [3:0] overflow_o
);
  typedef enum logic {S_IDLE, S_OFFER} state_t;

  function automatic logic is_legal(input logic [3:0] c);
    case (c)
      4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0011, 4'b1100: is_legal = 1'b1;
      default:                                             is_legal = 1'b0;
    endcase
  endfunction

  logic [3:0][3:0] ctrl, head;
  logic [3:0]      legal, push, pop, drop, empty, full, flush, cand, gpend;
  logic [3:0]      act_q, ovf_q, ovf_d;
  state_t          state_q, state_d;
  logic [1:0]      player_q, player_d, last_q, last_d, win, idx;
  logic [3:0]      code_q, code_d;
  logic            grav_q, grav_d, found;

  assign ctrl  = {control3_i, control2_i, control1_i, control0_i};
  // Falling edge of player_active empties that player's queue on the next edge.
  assign flush = act_q & ~player_active_i;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign legal[g] = is_legal(ctrl[g]) & player_active_i[g];
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push[g]  = legal[g] & (~full[g] | pop[g]);
    assign drop[g]  = legal[g] & full[g] & ~pop[g];

    player_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i   (clock_i),
      .rst_i   (reset_i),
      .push_i  (push[g]),
      .pop_i   (pop[g]),
      .flush_i (flush[g]),
      .data_i  (ctrl[g]),
      .data_o  (head[g]),
      .empty_o (empty[g]),
      .full_o  (full[g])
    );
  end

  assign ovf_d = ovf_q | drop;

`ifdef GRAVITY_EN
  localparam int GCW = (GRAVITY_PERIOD > 1) ? $clog2(GRAVITY_PERIOD) : 1;
  logic [GCW-1:0] gcnt_q, gcnt_d;
  logic [3:0]     gpend_q, gpend_d, gclr;
  logic           tick;

  assign tick    = (gcnt_q == GCW'(GRAVITY_PERIOD - 1));
  assign gcnt_d  = tick ? '0 : gcnt_q + 1'b1;
  // A new tick re-arms a bit even on the edge its previous request is served.
  assign gpend_d = (gpend_q & ~gclr & ~flush) | ({4{tick}} & player_active_i);
  assign gpend   = gpend_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      gcnt_q  <= '0;
      gpend_q <= '0;
    end else begin
      gcnt_q  <= gcnt_d;
      gpend_q <= gpend_d;
    end
  end
`else
  assign gpend = '0;
`endif

  assign cand = player_active_i & (~empty | gpend);

  // Round-robin: first candidate after last_q, wrapping 0..3.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      player_q <= '0;
      code_q   <= '0;
      grav_q   <= 1'b0;
      last_q   <= 2'd3;
      act_q    <= '0;
      ovf_q    <= '0;
    end else begin
      state_q  <= state_d;
      player_q <= player_d;
      code_q   <= code_d;
      grav_q   <= grav_d;
      last_q   <= last_d;
      act_q    <= player_active_i;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    player_d = player_q;
    code_d   = code_q;
    grav_d   = grav_q;
    last_d   = last_q;
    pop      = '0;
`ifdef GRAVITY_EN
    gclr     = '0;
`endif
    if (state_q == S_IDLE || cmd_ready_i) begin
      if (found) begin
        state_d  = S_OFFER;
        player_d = win;
        last_d   = win;
        if (gpend[win]) begin
          code_d = 4'b0010;
          grav_d = 1'b1;
`ifdef GRAVITY_EN
          gclr[win] = 1'b1;
`endif
        end else begin
          code_d   = head[win];
          grav_d   = 1'b0;
          pop[win] = 1'b1;
        end
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  always_comb begin
    cmd_valid_o   = (state_q == S_OFFER);
    cmd_player_o  = player_q;
    cmd_code_o    = code_q;
    cmd_gravity_o = grav_q;
    overflow_o    = ovf_q;
  end
endmodule

// File: tb/tb_player_cmd_arbiter.sv
// Directed checks of player_cmd_arbiter: vector table plus hand-written hold/reset/gravity sequences.

module tb_player_cmd_arbiter;
`ifdef GRAVITY_EN
  localparam int GP = 8;
`else
  localparam int GP = 50000000;
`endif

  logic       clk = 1'b0, rst = 1'b1;
  logic [3:0] c0 = '0, c1 = '0, c2 = '0, c3 = '0, act = 4'hF;
  logic       rdy = 1'b1;
  logic       vld, grav;
  logic [1:0] ply;
  logic [3:0] code, ovf;
  int         n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  player_cmd_arbiter #(.DEPTH(4), .GRAVITY_PERIOD(GP)) dut (
    .clock_i(clk), .reset_i(rst),
    .control0_i(c0), .control1_i(c1), .control2_i(c2), .control3_i(c3),
    .player_active_i(act), .cmd_ready_i(rdy),
    .cmd_valid_o(vld), .cmd_player_o(ply), .cmd_code_o(code),
    .cmd_gravity_o(grav), .overflow_o(ovf)
  );

  typedef struct {
    logic [3:0] c0, c1, c2, c3, act;
    logic       rdy, ev;
    logic [1:0] ep;
    logic [3:0] ec, eo;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic [3:0] a0, a1, a2, a3, ac, input logic r, e,
                              input logic [1:0] p, input logic [3:0] c, o);
    vec_t v;
    v.c0 = a0; v.c1 = a1; v.c2 = a2; v.c3 = a3; v.act = ac;
    v.rdy = r; v.ev = e; v.ep = p; v.ec = c; v.eo = o;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    c0 = '0; c1 = '0; c2 = '0; c3 = '0;
  endtask

  initial begin
    #12;
    chk("reset_valid", vld, 1'b0);
    chk("reset_player", ply, 2'd0);
    chk("reset_code", code, 4'd0);
    chk("reset_gravity", grav, 1'b0);
    chk("reset_overflow", ovf, 4'd0);
    rst = 1'b0;

`ifdef GRAVITY_EN
    // Counter wraps on the 8th live edge; key for player 0 arrives on that same edge.
    for (int i = 1; i <= 7; i++) begin
      step;
      chk("grav_pre_valid", vld, 1'b0);
    end
    c0 = 4'h1;
    step;
    idle_in;
    chk("grav_tick_valid", vld, 1'b0);
    for (int p = 0; p < 4; p++) begin
      step;
      chk("grav_valid", vld, 1'b1);
      chk("grav_player", ply, p);
      chk("grav_code", code, 4'h2);
      chk("grav_flag", grav, 1'b1);
    end
    step;
    chk("grav_key_valid", vld, 1'b1);
    chk("grav_key_player", ply, 2'd0);
    chk("grav_key_code", code, 4'h1);
    chk("grav_key_flag", grav, 1'b0);
    step;
    chk("grav_done_valid", vld, 1'b0);
`else
    // c0  c1  c2  c3  act rdy ev ep ec eo
    tv.push_back(mk(4'h1,4'h8,4'h4,4'h2,4'hF,1,0,0,4'h0,4'h0)); // all four push
    tv.push_back(mk(4'h0,4'h0,4'h0,4'h0,4'hF,1,1,0,4'h1,4'h0));
    tv.push_back(mk(4'h0,4'h0,4'h0,4'h0,4'hF,1,1,1,4'h8,4'h0));
    tv.push_back(mk(4'h0,4'h0,4'h0,4'h0,4'hF,1,1,2,4'h4,4'h0));
    tv.push_back(mk(4'h0,4'h0,4'h0,4'h0,4'hF,1,1,3,4'h2,4'h0));
    tv.push_back(mk(4'h0,4'h0,4'h0,4'h0,4'hF,1,0,0,4'h0,4'h0));
    tv.push_back(mk(4'h3,4'h0,4'h0,4'h0,4'hF,1,0,0,4'h0,4'h0)); // single-pulse latency
    tv.push_back(mk(4'h0,4'h0,4'h0,4'h0,4'hF,1,1,0,4'h3,4'h0));
    tv.push_back(mk(4'h0,4'h0,4'h0,4'h0,4'hF,1,0,0,4'h0,4'h0));
    tv.push_back(mk(4'h0,4'h5,4'h0,4'h0,4'hF,1,0,0,4'h0,4'h0)); // illegal code
    tv.push_back(mk(4'h0,4'h0,4'h0,4'h0,4'hF,1,0,0,4'h0,4'h0));
    tv.push_back(mk(4'h0,4'h0,4'h1,4'h0,4'hF,0,0,0,4'h0,4'h0)); // player 2 overflow
    tv.push_back(mk(4'h0,4'h0,4'h0,4'h0,4'hF,0,1,2,4'h1,4'h0));
    tv.push_back(mk(4'h0,4'h0,4'h8,4'h0,4'hF,0,1,2,4'h1,4'h0));
    tv.push_back(mk(4'h0,4'h0,4'h4,4'h0,4'hF,0,1,2,4'h1,4'h0));
    tv.push_back(mk(4'h0,4'h0,4'h2,4'h0,4'hF,0,1,2,4'h1,4'h0));
    tv.push_back(mk(4'h0,4'h0,4'h3,4'h0,4'hF,0,1,2,4'h1,4'h0));
    tv.push_back(mk(4'h0,4'h0,4'hC,4'h0,4'hF,0,1,2,4'h1,4'h4));
    tv.push_back(mk(4'h0,4'h0,4'h0,4'h0,4'hF,1,1,2,4'h8,4'h4));
    tv.push_back(mk(4'h0,4'h0,4'h0,4'h0,4'hF,1,1,2,4'h4,4'h4));
    tv.push_back(mk(4'h0,4'h0,4'h0,4'h0,4'hF,1,1,2,4'h2,4'h4));
    tv.push_back(mk(4'h0,4'h0,4'h0,4'h0,4'hF,1,1,2,4'h3,4'h4));
    tv.push_back(mk(4'h0,4'h0,4'h0,4'h0,4'hF,1,0,0,4'h0,4'h4));
    tv.push_back(mk(4'h0,4'h0,4'h0,4'h1,4'hF,0,0,0,4'h0,4'h4)); // player 3 push+pop on full
    tv.push_back(mk(4'h0,4'h0,4'h0,4'h0,4'hF,0,1,3,4'h1,4'h4));
    tv.push_back(mk(4'h0,4'h0,4'h0,4'h8,4'hF,0,1,3,4'h1,4'h4));
    tv.push_back(mk(4'h0,4'h0,4'h0,4'h4,4'hF,0,1,3,4'h1,4'h4));
    tv.push_back(mk(4'h0,4'h0,4'h0,4'h2,4'hF,0,1,3,4'h1,4'h4));
    tv.push_back(mk(4'h0,4'h0,4'h0,4'h3,4'hF,0,1,3,4'h1,4'h4));
    tv.push_back(mk(4'h0,4'h0,4'h0,4'hC,4'hF,1,1,3,4'h8,4'h4));
    tv.push_back(mk(4'h0,4'h0,4'h0,4'h0,4'hF,1,1,3,4'h4,4'h4));
    tv.push_back(mk(4'h0,4'h0,4'h0,4'h0,4'hF,1,1,3,4'h2,4'h4));
    tv.push_back(mk(4'h0,4'h0,4'h0,4'h0,4'hF,1,1,3,4'h3,4'h4));
    tv.push_back(mk(4'h0,4'h0,4'h0,4'h0,4'hF,1,1,3,4'hC,4'h4));
    tv.push_back(mk(4'h0,4'h0,4'h0,4'h0,4'hF,1,0,0,4'h0,4'h4));
    tv.push_back(mk(4'h0,4'h1,4'h0,4'h0,4'hF,0,0,0,4'h0,4'h4)); // player 1 deactivation
    tv.push_back(mk(4'h0,4'h0,4'h0,4'h0,4'hF,0,1,1,4'h1,4'h4));
    tv.push_back(mk(4'h0,4'h8,4'h0,4'h0,4'hF,0,1,1,4'h1,4'h4));
    tv.push_back(mk(4'h0,4'h4,4'h0,4'h0,4'hF,0,1,1,4'h1,4'h4));
    tv.push_back(mk(4'h0,4'h2,4'h0,4'h0,4'hF,0,1,1,4'h1,4'h4));
    tv.push_back(mk(4'h0,4'h3,4'h0,4'h0,4'hD,0,1,1,4'h1,4'h4));
    tv.push_back(mk(4'h0,4'h1,4'h0,4'h0,4'hD,1,0,0,4'h0,4'h4));
    tv.push_back(mk(4'h0,4'h0,4'h0,4'h0,4'hD,1,0,0,4'h0,4'h4));
    tv.push_back(mk(4'h0,4'h0,4'h0,4'h0,4'hF,1,0,0,4'h0,4'h4));

    foreach (tv[i]) begin
      c0 = tv[i].c0; c1 = tv[i].c1; c2 = tv[i].c2; c3 = tv[i].c3;
      act = tv[i].act; rdy = tv[i].rdy;
      step;
      chk($sformatf("v%0d_valid", i), vld, tv[i].ev);
      chk($sformatf("v%0d_overflow", i), ovf, tv[i].eo);
      if (tv[i].ev) begin
        chk($sformatf("v%0d_player", i), ply, tv[i].ep);
        chk($sformatf("v%0d_code", i), code, tv[i].ec);
        chk($sformatf("v%0d_gravity", i), grav, 1'b0);
      end
    end
    idle_in;

    // Offer held for 10 cycles of ready low, then handshake brings the next winner.
    rdy = 1'b0; c0 = 4'h1; c2 = 4'h8;
    step;
    idle_in;
    chk("hold_push_valid", vld, 1'b0);
    step;
    for (int i = 0; i < 10; i++) begin
      chk("hold_offer", {vld, ply, code, grav}, {1'b1, 2'd2, 4'h8, 1'b0});
      step;
    end
    chk("hold_offer_last", {vld, ply, code, grav}, {1'b1, 2'd2, 4'h8, 1'b0});
    rdy = 1'b1;
    step;
    chk("hold_next", {vld, ply, code}, {1'b1, 2'd0, 4'h1});

    // Asynchronous reset in the middle of an offer, with a command still queued.
    rdy = 1'b0; c3 = 4'h2;
    step;
    idle_in;
    chk("pre_reset_valid", vld, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_valid", vld, 1'b0);
    chk("async_reset_overflow", ovf, 4'd0);
    chk("async_reset_code", code, 4'd0);
    #3 rst = 1'b0;
    rdy = 1'b1;
    step;
    chk("post_reset_valid0", vld, 1'b0);
    step;
    chk("post_reset_valid1", vld, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
